// File: rtl/bar_pkg.sv
// rtl/bar_pkg.sv - direction indices, screen bounds and arbiter helper for the bar move scheduler
package bar_pkg;

  localparam int DIR_L = 0;
  localparam int DIR_R = 1;
  localparam int DIR_U = 2;
  localparam int DIR_D = 3;

  localparam int STEP_PX  = 16;
  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;

  // A step is refused when it would push the bar partly off screen.
  localparam logic [9:0] LEFT_MIN   = 10'(STEP_PX);
  localparam logic [9:0] RIGHT_MAX  = 10'(SCREEN_W - STEP_PX - 1);
  localparam logic [9:0] TOP_MIN    = 10'(STEP_PX);
  localparam logic [9:0] BOTTOM_MAX = 10'(SCREEN_H - STEP_PX - 1);

  typedef enum logic [1:0] {
    RPT_IDLE   = 2'd0,
    RPT_DELAY  = 2'd1,
    RPT_REPEAT = 2'd2
  } rpt_state_e;

  function automatic logic [1:0] rr_pick(input logic [3:0] avail, input logic [1:0] ptr);
    logic [1:0] idx;
    logic [1:0] pick;
    pick = ptr;
    for (int i = 3; i >= 0; i--) begin
      idx = ptr + 2'(i);
      if (avail[idx]) pick = idx;
    end
    return pick;
  endfunction

endpackage

// File: rtl/key_repeat.sv
// rtl/key_repeat.sv - per-key synchroniser, debouncer and auto-repeat FSM emitting 1-cycle request pulses
module key_repeat
  import bar_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 500000,
  parameter int FIRST_DELAY  = 12500000,
  parameter int REPEAT_CYC   = 4000000,
  parameter int CNT_W        = 32
) (
  input  logic clk,
  input  logic rst_n,
  input  logic flush,
  input  logic key_n,
  output logic req
);

  logic             s1_q, s1_d, s2_q, s2_d;
  logic             deb_q, deb_d;
  logic [CNT_W-1:0] dcnt_q, dcnt_d;
  logic [CNT_W-1:0] rcnt_q, rcnt_d;
  rpt_state_e       state_q, state_d;
  logic             pressed;

  assign pressed = ~deb_q;

  always_comb begin
    s1_d   = key_n;
    s2_d   = s1_q;
    deb_d  = deb_q;
    dcnt_d = '0;
    if (s2_q != deb_q) begin
      if (dcnt_q == CNT_W'(DEBOUNCE_CYC - 1)) deb_d = s2_q;
      else dcnt_d = dcnt_q + 1'b1;
    end
  end

  // Release wins over any pending repeat so no request escapes after the key goes up.
  always_comb begin
    state_d = state_q;
    rcnt_d  = rcnt_q;
    req     = 1'b0;
    if (flush || !pressed) begin
      state_d = RPT_IDLE;
      rcnt_d  = '0;
    end else begin
      case (state_q)
        RPT_IDLE: begin
          req     = 1'b1;
          state_d = RPT_DELAY;
          rcnt_d  = '0;
        end
        RPT_DELAY: begin
          if (rcnt_q == CNT_W'(FIRST_DELAY - 1)) begin
            req     = 1'b1;
            state_d = RPT_REPEAT;
            rcnt_d  = '0;
          end else begin
            rcnt_d = rcnt_q + 1'b1;
          end
        end
        RPT_REPEAT: begin
          if (rcnt_q == CNT_W'(REPEAT_CYC - 1)) begin
            req    = 1'b1;
            rcnt_d = '0;
          end else begin
            rcnt_d = rcnt_q + 1'b1;
          end
        end
        default: begin
          state_d = RPT_IDLE;
          rcnt_d  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q    <= 1'b1;
      s2_q    <= 1'b1;
      deb_q   <= 1'b1;
      dcnt_q  <= '0;
      rcnt_q  <= '0;
      state_q <= RPT_IDLE;
    end else begin
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      deb_q   <= deb_d;
      dcnt_q  <= dcnt_d;
      rcnt_q  <= rcnt_d;
      state_q <= state_d;
    end
  end

endmodule

// File: rtl/bar_move_scheduler.sv
// rtl/bar_move_scheduler.sv - key-to-step scheduler with edge masking and RR arbitration
// Optional diagonal steps when BAR_DIAG_EN is defined.
module bar_move_scheduler
  import bar_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 500000,
  parameter int FIRST_DELAY  = 12500000,
  parameter int REPEAT_CYC   = 4000000,
  parameter int CNT_W        = 32
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       game_state,
  input  logic       keyLeft,
  input  logic       keyRight,
  input  logic       keyUp,
  input  logic       keyDown,
  input  logic [9:0] bar_leftLimit,
  input  logic [9:0] bar_rightLimit,
  input  logic [9:0] bar_topLimit,
  input  logic [9:0] bar_bottomLimit,
  output logic       step_valid,
  output logic [3:0] step_dir,
  input  logic       step_ready
);

  logic [3:0] req_vec, blocked, conflict, merged, avail, grant;
  logic [3:0] pending_q, pending_d;
  logic [3:0] step_dir_q, step_dir_d;
  logic       step_valid_q, step_valid_d;
  logic [1:0] ptr_q, ptr_d;
  logic [1:0] pick;
  logic [3:0] keys_n;

  assign keys_n = {keyDown, keyUp, keyRight, keyLeft};

  for (genvar g = 0; g < 4; g++) begin : g_key
    key_repeat #(
      .DEBOUNCE_CYC(DEBOUNCE_CYC),
      .FIRST_DELAY (FIRST_DELAY),
      .REPEAT_CYC  (REPEAT_CYC),
      .CNT_W       (CNT_W)
    ) u_key (
      .clk  (CLOCK_50),
      .rst_n(reset),
      .flush(game_state),
      .key_n(keys_n[g]),
      .req  (req_vec[g])
    );
  end

  always_comb begin
    blocked        = '0;
    blocked[DIR_L] = bar_leftLimit < LEFT_MIN;
    blocked[DIR_R] = bar_rightLimit > RIGHT_MAX;
    blocked[DIR_U] = bar_topLimit < TOP_MIN;
    blocked[DIR_D] = bar_bottomLimit > BOTTOM_MAX;
  end

  // Opposing requests cancel each other rather than being issued in either order.
  always_comb begin
    merged          = pending_q | req_vec;
    conflict        = '0;
    conflict[DIR_L] = merged[DIR_L] & merged[DIR_R];
    conflict[DIR_R] = merged[DIR_L] & merged[DIR_R];
    conflict[DIR_U] = merged[DIR_U] & merged[DIR_D];
    conflict[DIR_D] = merged[DIR_U] & merged[DIR_D];
    avail           = pending_q & ~blocked;
  end

  always_comb begin
    grant = '0;
    ptr_d = ptr_q;
    pick  = rr_pick(avail, ptr_q);
    if (!step_valid_q && !game_state && avail != 4'b0000) begin
`ifdef BAR_DIAG_EN
      if ((avail[DIR_L] | avail[DIR_R]) && (avail[DIR_U] | avail[DIR_D])) begin
        grant[DIR_L] = avail[DIR_L];
        grant[DIR_R] = avail[DIR_R] & ~avail[DIR_L];
        grant[DIR_U] = avail[DIR_U];
        grant[DIR_D] = avail[DIR_D] & ~avail[DIR_U];
        ptr_d        = avail[DIR_U] ? 2'(DIR_D) : 2'(DIR_L);
      end else begin
        grant = 4'b0001 << pick;
        ptr_d = pick + 2'd1;
      end
`else
      grant = 4'b0001 << pick;
      ptr_d = pick + 2'd1;
`endif
    end
  end

  always_comb begin
    step_valid_d = step_valid_q;
    step_dir_d   = step_dir_q;
    if (game_state) begin
      step_valid_d = 1'b0;
      step_dir_d   = '0;
    end else if (grant != 4'b0000) begin
      step_valid_d = 1'b1;
      step_dir_d   = grant;
    end else if (step_valid_q && step_ready) begin
      step_valid_d = 1'b0;
      step_dir_d   = '0;
    end
    pending_d = game_state ? 4'b0000 : (merged & ~blocked & ~conflict & ~grant);
  end

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      pending_q    <= '0;
      step_dir_q   <= '0;
      step_valid_q <= 1'b0;
      ptr_q        <= 2'(DIR_L);
    end else begin
      pending_q    <= pending_d;
      step_dir_q   <= step_dir_d;
      step_valid_q <= step_valid_d;
      ptr_q        <= ptr_d;
    end
  end

  assign step_valid = step_valid_q;
  assign step_dir   = step_dir_q;

endmodule

// File: tb/tb_bar_move_scheduler.sv
// tb/tb_bar_move_scheduler.sv - directed self-checking bench for bar_move_scheduler
module tb_bar_move_scheduler;

  logic       CLOCK_50 = 1'b0;
  logic       reset = 1'b0;
  logic       game_state = 1'b0;
  logic       keyLeft = 1'b1, keyRight = 1'b1, keyUp = 1'b1, keyDown = 1'b1;
  logic [9:0] bar_leftLimit = 10'd256, bar_rightLimit = 10'd320;
  logic [9:0] bar_topLimit = 10'd200, bar_bottomLimit = 10'd264;
  logic       step_valid;
  logic [3:0] step_dir;
  logic       step_ready = 1'b1;

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;
  int log_cyc[$];
  logic [3:0] log_dir[$];

  bar_move_scheduler #(
    .DEBOUNCE_CYC(4),
    .FIRST_DELAY (20),
    .REPEAT_CYC  (8),
    .CNT_W       (32)
  ) dut (
    .CLOCK_50       (CLOCK_50),
    .reset          (reset),
    .game_state     (game_state),
    .keyLeft        (keyLeft),
    .keyRight       (keyRight),
    .keyUp          (keyUp),
    .keyDown        (keyDown),
    .bar_leftLimit  (bar_leftLimit),
    .bar_rightLimit (bar_rightLimit),
    .bar_topLimit   (bar_topLimit),
    .bar_bottomLimit(bar_bottomLimit),
    .step_valid     (step_valid),
    .step_dir       (step_dir),
    .step_ready     (step_ready)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  always @(posedge CLOCK_50) cyc++;

  always @(negedge CLOCK_50) begin
    if (reset && step_valid && step_ready) begin
      log_cyc.push_back(cyc);
      log_dir.push_back(step_dir);
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLOCK_50);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic log_clear();
    log_cyc.delete();
    log_dir.delete();
  endtask

  task automatic wait_valid(input int max, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      if (step_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick(1);
    end
  endtask

  initial begin
    int   fall;
    int   stable_err;
    logic ok;
    int   exp_off[6] = '{0, 20, 28, 36, 44, 52};

    tick(3);
    chk("reset_valid", 32'(step_valid), 32'd0);
    chk("reset_dir", 32'(step_dir), 32'd0);
    reset = 1'b1;
    tick(10);

    // Single tap of Right
    log_clear();
    fall = cyc;
    keyRight = 1'b0;
    tick(10);
    keyRight = 1'b1;
    tick(30);
    chk("tap_r_count", 32'(log_dir.size()), 32'd1);
    if (log_dir.size() >= 1) begin
      chk("tap_r_dir", 32'(log_dir[0]), 32'b0010);
      chk("tap_r_latency", 32'(log_cyc[0] - fall), 32'd8);
    end

    // Hold Down for auto-repeat
    log_clear();
    fall = cyc;
    keyDown = 1'b0;
    tick(60);
    keyDown = 1'b1;
    tick(40);
    chk("hold_d_count", 32'(log_dir.size()), 32'd6);
    if (log_dir.size() == 6) begin
      chk("hold_d_first", 32'(log_cyc[0] - fall), 32'd8);
      for (int i = 0; i < 6; i++) begin
        chk($sformatf("hold_d_off%0d", i), 32'(log_cyc[i] - log_cyc[0]), 32'(exp_off[i]));
        chk($sformatf("hold_d_dir%0d", i), 32'(log_dir[i]), 32'b1000);
      end
    end

    // Glitches on Up
    log_clear();
    keyUp = 1'b0;
    tick(3);
    keyUp = 1'b1;
    tick(20);
    chk("glitch3_count", 32'(log_dir.size()), 32'd0);
    log_clear();
    keyUp = 1'b0;
    tick(4);
    keyUp = 1'b1;
    tick(20);
    chk("press4_count", 32'(log_dir.size()), 32'd1);
    if (log_dir.size() >= 1) chk("press4_dir", 32'(log_dir[0]), 32'b0100);

    // Left blocked at screen edge
    log_clear();
    bar_leftLimit = 10'd0;
    keyLeft = 1'b0;
    tick(40);
    keyLeft = 1'b1;
    tick(20);
    chk("blocked_l_count", 32'(log_dir.size()), 32'd0);
    chk("blocked_l_pending", 32'(dut.pending_q[0]), 32'd0);
    bar_leftLimit = 10'd256;

    // L and R together cancel
    log_clear();
    keyLeft = 1'b0;
    keyRight = 1'b0;
    tick(15);
    keyLeft = 1'b1;
    keyRight = 1'b1;
    tick(20);
    chk("lr_conflict_count", 32'(log_dir.size()), 32'd0);

    // U and R together
    log_clear();
    keyUp = 1'b0;
    keyRight = 1'b0;
    tick(10);
    keyUp = 1'b1;
    keyRight = 1'b1;
    tick(20);
`ifdef BAR_DIAG_EN
    chk("ur_diag_count", 32'(log_dir.size()), 32'd1);
    if (log_dir.size() >= 1) chk("ur_diag_dir", 32'(log_dir[0]), 32'b0110);
`else
    chk("ur_count", 32'(log_dir.size()), 32'd2);
    if (log_dir.size() == 2) begin
      chk("ur_first", 32'(log_dir[0]), 32'b0010);
      chk("ur_second", 32'(log_dir[1]), 32'b0100);
      chk("ur_spacing", 32'(log_cyc[1] - log_cyc[0]), 32'd2);
    end
`endif

    // Backpressure holds the command stable
    log_clear();
    step_ready = 1'b0;
    keyLeft = 1'b0;
    tick(10);
    keyLeft = 1'b1;
    wait_valid(20, ok);
    chk("bp_wait_valid", 32'(ok), 32'd1);
    stable_err = 0;
    for (int i = 0; i < 30; i++) begin
      tick(1);
      if (!(step_valid === 1'b1 && step_dir === 4'b0001)) stable_err++;
    end
    chk("bp_stable", 32'(stable_err), 32'd0);
    chk("bp_no_accept", 32'(log_dir.size()), 32'd0);
    step_ready = 1'b1;
    tick(1);
    chk("bp_accept_count", 32'(log_dir.size()), 32'd1);
    chk("bp_valid_drop", 32'(step_valid), 32'd0);
    tick(20);

    // game_state flush
    log_clear();
    step_ready = 1'b0;
    keyDown = 1'b0;
    tick(5);
    keyDown = 1'b1;
    wait_valid(20, ok);
    chk("gs_wait_valid", 32'(ok), 32'd1);
    chk("gs_dir", 32'(step_dir), 32'b1000);
    game_state = 1'b1;
    tick(1);
    chk("gs_valid_clear", 32'(step_valid), 32'd0);
    chk("gs_dir_clear", 32'(step_dir), 32'd0);
    tick(10);
    game_state = 1'b0;
    step_ready = 1'b1;
    tick(20);
    chk("gs_no_step", 32'(log_dir.size()), 32'd0);

    // Async reset mid-handshake
    step_ready = 1'b0;
    keyRight = 1'b0;
    tick(5);
    keyRight = 1'b1;
    wait_valid(20, ok);
    chk("rst_wait_valid", 32'(ok), 32'd1);
    reset = 1'b0;
    #1;
    chk("rst_async_valid", 32'(step_valid), 32'd0);
    chk("rst_async_dir", 32'(step_dir), 32'd0);
    tick(3);
    reset = 1'b1;
    step_ready = 1'b1;
    tick(10);
    chk("rst_after_valid", 32'(step_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
